// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station schedulers: tag width,
// the "no dependency" tag and the scheduler FSM encoding.
package rs_pkg;

    localparam int TAG_W       = 4;
    localparam logic [TAG_W-1:0] NO_TAG = '0;
    localparam int ADD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        BCAST = 2'd2
    } sched_state_t;

endpackage

// File: rtl/add_rs_sched_if.sv
// Issue / reservation-station / CDB signals between the add scheduler and its
// neighbours. master = scheduler side, slave = decode, RS pool and CDB side.
interface add_rs_sched_if #(
    parameter int NUM_RS = 3
);
    import rs_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [NUM_RS-1:0] rs_sel;
    logic [NUM_RS-1:0] rs_busy;
    logic [NUM_RS-1:0] rs_ready;
    logic [NUM_RS-1:0] fu_grant;
    logic              cdb_req;
    logic              cdb_ack;
    logic [TAG_W-1:0]  cdb_tag;
    logic [NUM_RS-1:0] rs_done;

    modport master (
        input  issue_valid, rs_busy, rs_ready, cdb_ack,
        output issue_ready, issue_tag, rs_sel, fu_grant, cdb_req, cdb_tag, rs_done
    );

    modport slave (
        output issue_valid, rs_busy, rs_ready, cdb_ack,
        input  issue_ready, issue_tag, rs_sel, fu_grant, cdb_req, cdb_tag, rs_done
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past ptr,
// wrapping modulo N, and returns a one-hot grant (zero when req is zero).
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_rs_sched.sv
// Add reservation-station scheduler: allocates free entries to issued add/sub
// ops, shares the single adder round-robin, and retires entries after the CDB.
module add_rs_sched
    import rs_pkg::*;
#(
    parameter int NUM_RS   = 3,
    parameter int TAG_BASE = 1,
    parameter int ADD_LAT  = ADD_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    add_rs_sched_if.master bus
);

    localparam int               IW         = $clog2(NUM_RS);
    localparam logic [TAG_W-1:0] TAG_BASE_T = TAG_W'(TAG_BASE);
    localparam logic [1:0]       CNT_INIT   = 2'(ADD_LAT - 1);

    generate
        if (TAG_BASE + NUM_RS - 1 > 15) begin : g_bad_tag_range
            $error("add_rs_sched: TAG_BASE+NUM_RS-1 exceeds the 4-bit tag space");
        end
        if (NUM_RS < 2 || NUM_RS > 8) begin : g_bad_num_rs
            $error("add_rs_sched: NUM_RS must be in 2..8");
        end
        if (ADD_LAT < 1 || ADD_LAT > 4) begin : g_bad_add_lat
            $error("add_rs_sched: ADD_LAT must be in 1..4");
        end
    endgenerate

    // Allocation state and lowest-index free entry
    logic [NUM_RS-1:0] reserved;
    logic [NUM_RS-1:0] rs_sel_r;
    logic [NUM_RS-1:0] free;
    logic [NUM_RS-1:0] alloc_oh;
    logic [IW-1:0]     alloc_idx;
    logic              issue_fire;

    assign free = ~bus.rs_busy & ~reserved;

    always_comb begin
        alloc_oh  = '0;
        alloc_idx = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (free[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
                alloc_idx   = IW'(i);
            end
        end
    end

    assign bus.issue_ready = |free;
    assign bus.issue_tag   = TAG_BASE_T + TAG_W'(alloc_idx);
    assign issue_fire      = bus.issue_valid & bus.issue_ready;
    assign bus.rs_sel      = rs_sel_r;

    // Reserved covers the gap until the loaded entry reports busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_sel_r <= '0;
            reserved <= '0;
        end else if (flush) begin
            rs_sel_r <= '0;
            reserved <= '0;
        end else begin
            rs_sel_r <= issue_fire ? alloc_oh : '0;
            reserved <= (reserved & ~bus.rs_busy) | (issue_fire ? alloc_oh : '0);
        end
    end

    // Execution scheduling
    sched_state_t      state;
    logic [1:0]        cnt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [NUM_RS-1:0] fu_grant_r;
    logic              cdb_req_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [NUM_RS-1:0] rs_done_r;
    logic [NUM_RS-1:0] arb_req;
    logic [NUM_RS-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;

    // The just-retired entry still shows ready for one cycle; mask it.
    assign arb_req = bus.rs_ready & ~fu_grant_r & ~rs_done_r;

    rr_arbiter #(.N(NUM_RS)) u_arb (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (arb_gnt[i]) arb_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= IW'(NUM_RS - 1);
            owner      <= '0;
            fu_grant_r <= '0;
            cdb_req_r  <= 1'b0;
            cdb_tag_r  <= NO_TAG;
            rs_done_r  <= '0;
        end else begin
            rs_done_r <= '0;
            if (flush) begin
                state      <= IDLE;
                cnt        <= '0;
                fu_grant_r <= '0;
                cdb_req_r  <= 1'b0;
                cdb_tag_r  <= NO_TAG;
            end else begin
                case (state)
                    IDLE: begin
                        if (|arb_req) begin
                            fu_grant_r <= arb_gnt;
                            owner      <= arb_idx;
                            cnt        <= CNT_INIT;
                            state      <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (cnt != 2'd0) begin
                            cnt <= cnt - 2'd1;
                        end else begin
                            cdb_req_r <= 1'b1;
                            cdb_tag_r <= TAG_BASE_T + TAG_W'(owner);
                            state     <= BCAST;
                        end
                    end
                    BCAST: begin
                        if (bus.cdb_ack) begin
                            rs_done_r  <= fu_grant_r;
                            rr_ptr     <= owner;
                            fu_grant_r <= '0;
                            cdb_req_r  <= 1'b0;
                            cdb_tag_r  <= NO_TAG;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.fu_grant = fu_grant_r;
    assign bus.cdb_req  = cdb_req_r;
    assign bus.cdb_tag  = cdb_tag_r;
    assign bus.rs_done  = rs_done_r;

endmodule

// File: tb/tb_add_rs_sched.sv
// Directed bench for add_rs_sched: allocation, round-robin execution,
// CDB back-pressure, flush and asynchronous reset.
module tb_add_rs_sched;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    add_rs_sched_if #(.NUM_RS(3)) bus ();

    add_rs_sched #(.NUM_RS(3), .TAG_BASE(1), .ADD_LAT(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // RS pool stand-in: busy follows rs_sel, or is forced directly
    logic       auto_busy;
    logic [2:0] busy_model;
    logic [2:0] busy_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_model <= '0;
        else     busy_model <= (busy_model | bus.rs_sel) & ~bus.rs_done;
    end

    assign bus.rs_busy = auto_busy ? busy_model : busy_force;

    typedef struct {
        logic       valid;
        logic       exp_ready;
        logic [3:0] exp_tag;
        logic [2:0] exp_sel;
    } alloc_vec_t;

    typedef struct {
        logic [2:0] gnt;
        logic       req;
        logic [3:0] tag;
        logic [2:0] done;
    } rr_vec_t;

    alloc_vec_t alloc_tbl [5];
    rr_vec_t    rr_tbl    [16];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        flush           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.rs_ready    = '0;
        bus.cdb_ack     = 1'b0;
        busy_force      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        alloc_tbl[0] = '{1'b1, 1'b1, 4'd1, 3'b001};
        alloc_tbl[1] = '{1'b1, 1'b1, 4'd2, 3'b010};
        alloc_tbl[2] = '{1'b1, 1'b1, 4'd3, 3'b100};
        alloc_tbl[3] = '{1'b1, 1'b0, 4'd0, 3'b000};
        alloc_tbl[4] = '{1'b0, 1'b0, 4'd0, 3'b000};

        rr_tbl[0]  = '{3'b001, 1'b0, 4'd0, 3'b000};
        rr_tbl[1]  = '{3'b001, 1'b0, 4'd0, 3'b000};
        rr_tbl[2]  = '{3'b001, 1'b1, 4'd1, 3'b000};
        rr_tbl[3]  = '{3'b000, 1'b0, 4'd0, 3'b001};
        rr_tbl[4]  = '{3'b010, 1'b0, 4'd0, 3'b000};
        rr_tbl[5]  = '{3'b010, 1'b0, 4'd0, 3'b000};
        rr_tbl[6]  = '{3'b010, 1'b1, 4'd2, 3'b000};
        rr_tbl[7]  = '{3'b000, 1'b0, 4'd0, 3'b010};
        rr_tbl[8]  = '{3'b100, 1'b0, 4'd0, 3'b000};
        rr_tbl[9]  = '{3'b100, 1'b0, 4'd0, 3'b000};
        rr_tbl[10] = '{3'b100, 1'b1, 4'd3, 3'b000};
        rr_tbl[11] = '{3'b000, 1'b0, 4'd0, 3'b100};
        rr_tbl[12] = '{3'b001, 1'b0, 4'd0, 3'b000};
        rr_tbl[13] = '{3'b001, 1'b0, 4'd0, 3'b000};
        rr_tbl[14] = '{3'b001, 1'b1, 4'd1, 3'b000};
        rr_tbl[15] = '{3'b000, 1'b0, 4'd0, 3'b001};

        // Reset state
        auto_busy = 1'b1;
        do_reset();
        chk("rst_fu_grant",    32'(bus.fu_grant),    0);
        chk("rst_rs_sel",      32'(bus.rs_sel),      0);
        chk("rst_cdb_req",     32'(bus.cdb_req),     0);
        chk("rst_cdb_tag",     32'(bus.cdb_tag),     0);
        chk("rst_rs_done",     32'(bus.rs_done),     0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_issue_tag",   32'(bus.issue_tag),   1);

        // Allocation: three tags, then stall
        for (int i = 0; i < 5; i++) begin
            bus.issue_valid = alloc_tbl[i].valid;
            #1;
            chk($sformatf("alloc%0d_ready", i), 32'(bus.issue_ready), 32'(alloc_tbl[i].exp_ready));
            if (alloc_tbl[i].exp_ready)
                chk($sformatf("alloc%0d_tag", i), 32'(bus.issue_tag), 32'(alloc_tbl[i].exp_tag));
            tick();
            chk($sformatf("alloc%0d_sel", i), 32'(bus.rs_sel), 32'(alloc_tbl[i].exp_sel));
        end
        bus.issue_valid = 1'b0;

        // Round-robin with all entries ready and CDB always accepting
        do_reset();
        auto_busy    = 1'b0;
        busy_force   = 3'b111;
        bus.rs_ready = 3'b111;
        bus.cdb_ack  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("rr%0d_grant", i), 32'(bus.fu_grant), 32'(rr_tbl[i].gnt));
            chk($sformatf("rr%0d_req", i),   32'(bus.cdb_req),  32'(rr_tbl[i].req));
            if (rr_tbl[i].req)
                chk($sformatf("rr%0d_tag", i), 32'(bus.cdb_tag), 32'(rr_tbl[i].tag));
            chk($sformatf("rr%0d_done", i),  32'(bus.rs_done),  32'(rr_tbl[i].done));
        end

        // CDB back-pressure on entry 1
        do_reset();
        busy_force   = 3'b010;
        bus.rs_ready = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("hold%0d_grant", k), 32'(bus.fu_grant), 32'h2);
            chk($sformatf("hold%0d_req", k),   32'(bus.cdb_req),  (k >= 3) ? 1 : 0);
            if (k >= 3) chk($sformatf("hold%0d_tag", k), 32'(bus.cdb_tag), 2);
            chk($sformatf("hold%0d_done", k),  32'(bus.rs_done),  0);
        end
        bus.cdb_ack = 1'b1;
        tick();
        bus.cdb_ack = 1'b0;
        chk("hold_ack_done",  32'(bus.rs_done),  32'h2);
        chk("hold_ack_req",   32'(bus.cdb_req),  0);
        chk("hold_ack_grant", 32'(bus.fu_grant), 0);
        tick();
        bus.rs_ready = '0;
        chk("hold_regrant_masked", 32'(bus.fu_grant), 0);
        chk("hold_done_one_cycle", 32'(bus.rs_done),  0);

        // Flush during EXEC
        do_reset();
        busy_force   = 3'b101;
        bus.rs_ready = 3'b001;
        tick();
        chk("flush_pre_grant", 32'(bus.fu_grant), 32'h1);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        bus.rs_ready = 3'b100;
        chk("flush_grant", 32'(bus.fu_grant), 0);
        chk("flush_req",   32'(bus.cdb_req),  0);
        chk("flush_done",  32'(bus.rs_done),  0);
        tick();
        chk("flush_next_grant", 32'(bus.fu_grant), 32'h4);
        tick();
        chk("flush_exec_req", 32'(bus.cdb_req), 0);
        tick();
        chk("flush_next_req", 32'(bus.cdb_req), 1);
        chk("flush_next_tag", 32'(bus.cdb_tag), 3);
        bus.cdb_ack = 1'b1;
        tick();
        bus.cdb_ack  = 1'b0;
        bus.rs_ready = '0;
        chk("flush_next_done", 32'(bus.rs_done), 32'h4);

        // Asynchronous reset mid-BCAST
        do_reset();
        busy_force   = 3'b011;
        bus.rs_ready = 3'b010;
        repeat (3) tick();
        chk("arst_pre_req", 32'(bus.cdb_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   32'(bus.cdb_req),  0);
        chk("arst_grant", 32'(bus.fu_grant), 0);
        chk("arst_tag",   32'(bus.cdb_tag),  0);
        chk("arst_done",  32'(bus.rs_done),  0);
        #1 rst = 1'b0;
        bus.rs_ready = 3'b011;
        tick();
        chk("arst_first_grant", 32'(bus.fu_grant), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
